// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// Module   : alu_pkg
// Brief    : Shared widths, opcodes, FSM states and the result-entry layout
//            for the ALU command driver.
// Revision : 1.0 - initial release
//============================================================================
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_AND  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // One queued response: {res, cf, err}, DATA_W+2 bits
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              cf;
        logic              err;
    } rsp_entry_t;

    // Opcode 3 is reserved; everything else maps to a real ALU operation
    function automatic logic op_is_legal(input logic [1:0] op);
        return (op != OP_RSVD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
//============================================================================
// Module   : rsp_fifo
// Brief    : Synchronous first-word-fall-through FIFO. The head entry is
//            presented whenever the FIFO is non-empty; the head reads as
//            zero while empty so downstream sees a clean bus after reset.
// Revision : 1.0 - initial release
//============================================================================
module rsp_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;
    logic               w_push;

    // A pop on an empty FIFO is a no-op; a push is dropped only if full
    // with no simultaneous pop, which the producer never allows
    assign w_pop      = pop && (r_count != '0);
    assign w_push     = push && ((r_count != c_DEPTH_CNT) || w_pop);
    assign head_valid = (r_count != '0);
    assign head_data  = head_valid ? r_mem[r_rd_ptr] : '0;
    assign count      = r_count;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
//============================================================================
// Module   : alu_cmd_driver
// Brief    : Accepts ALU commands over valid/ready, drives the combinational
//            ALU from registers, waits SETTLE_CYC cycles, captures res/cf
//            and queues the result in a FWFT FIFO for the consumer.
// Revision : 1.0 - initial release
//============================================================================
module alu_cmd_driver #(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int SETTLE_CYC = 1,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [DATA_W-1:0]        cmd_a,
    input  logic [DATA_W-1:0]        cmd_b,
    input  logic [1:0]               cmd_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [1:0]               alu_opsel,
    input  logic [DATA_W-1:0]        alu_res,
    input  logic                     alu_cf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_res,
    output logic                     rsp_cf,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    import alu_pkg::*;

    localparam int                        c_CNT_W       = 4;
    localparam int                        c_ENTRY_W     = DATA_W + 2;
    localparam logic [c_CNT_W-1:0]        c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [$clog2(DEPTH):0]    c_DEPTH_CNT   = ($clog2(DEPTH)+1)'(DEPTH);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_settle;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_push;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head;

    assign cmd_ready = (r_state == ST_IDLE) && (count < c_DEPTH_CNT);
    assign w_accept  = cmd_valid && cmd_ready;
    assign busy      = (r_state == ST_DRIVE);

    // A reserved opcode produces a zero result flagged as an error
    assign w_push_data = r_err ? {{DATA_W{1'b0}}, 1'b0, 1'b1}
                               : {alu_res, alu_cf, 1'b0};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and push decode: capture happens when the settle count expires
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_settle == '0) begin
                    w_push       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ALU drive registers, settle counter and error latch; alu_* only move on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_opsel <= '0;
            r_settle  <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_settle <= c_SETTLE_LOAD;
            r_err    <= !op_is_legal(cmd_op);
            if (op_is_legal(cmd_op)) begin
                alu_a     <= cmd_a;
                alu_b     <= cmd_b;
                alu_opsel <= cmd_op;
            end
        end else if ((r_state == ST_DRIVE) && (r_settle != '0)) begin
            r_settle <= r_settle - 1'b1;
        end
    end

    rsp_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (rsp_ready),
        .head_data  (w_head),
        .head_valid (rsp_valid),
        .count      (count)
    );

    assign {rsp_res, rsp_cf, rsp_err} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
//============================================================================
// Module   : tb_alu_cmd_driver
// Brief    : Scoreboard bench for alu_cmd_driver with a behavioural ALU.
//            Two instances: SETTLE_CYC=1 (main) and SETTLE_CYC=3 (capture
//            timing).
// Revision : 1.0 - initial release
//============================================================================
module tb_alu_cmd_driver;

    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance with SETTLE_CYC=1
    logic       cmd_valid, cmd_ready, alu_cf, rsp_valid, rsp_ready, rsp_cf, rsp_err, busy;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_res, rsp_res;
    logic [1:0] cmd_op, alu_opsel;
    logic [2:0] count;

    // Instance with SETTLE_CYC=3
    logic       d3_cmd_valid, d3_cmd_ready, d3_alu_cf, d3_rsp_valid, d3_rsp_ready, d3_rsp_cf, d3_rsp_err, d3_busy;
    logic [7:0] d3_cmd_a, d3_cmd_b, d3_alu_a, d3_alu_b, d3_alu_res, d3_rsp_res;
    logic [1:0] d3_cmd_op, d3_alu_opsel;
    logic [2:0] d3_count;
    logic [7:0] perturb;

    int         total = 0;
    int         bad   = 0;
    rsp_entry_t exp_q[$];
    logic [7:0] last_a, last_b;
    logic [1:0] last_op;

    // Combinational ALU: 0=ADD, 1=SUB (cf=borrow), 2=AND, 3 unused
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {(a < b), a - b};
            2'd2:    return {1'b0, a & b};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_cf, alu_res}       = alu_model(alu_a, alu_b, alu_opsel);
    assign {d3_alu_cf, d3_alu_res} = alu_model(d3_alu_a, d3_alu_b, d3_alu_opsel) ^ {1'b0, perturb};

    // Reference model: expected response for a command, from plain arithmetic
    function automatic rsp_entry_t ref_rsp(input int a, input int b, input int op);
        rsp_entry_t e;
        int t;
        e = '0;
        case (op)
            0: begin t = a + b; e.res = 8'(t % 256);         e.cf = (t > 255); end
            1: begin t = a - b; e.res = 8'((t + 256) % 256); e.cf = (t < 0);   end
            2: begin e.res = 8'(a & b); end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    alu_cmd_driver #(.DATA_W(8), .SETTLE_CYC(1), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel),
        .alu_res(alu_res), .alu_cf(alu_cf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_cf(rsp_cf), .rsp_err(rsp_err),
        .busy(busy), .count(count)
    );

    alu_cmd_driver #(.DATA_W(8), .SETTLE_CYC(3), .DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready),
        .cmd_a(d3_cmd_a), .cmd_b(d3_cmd_b), .cmd_op(d3_cmd_op),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_opsel(d3_alu_opsel),
        .alu_res(d3_alu_res), .alu_cf(d3_alu_cf),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
        .rsp_res(d3_rsp_res), .rsp_cf(d3_rsp_cf), .rsp_err(d3_rsp_err),
        .busy(d3_busy), .count(d3_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake edge pops the oldest expected response
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got res=0x%0h cf=%0b err=%0b with nothing expected at %0t",
                         rsp_res, rsp_cf, rsp_err, $time);
            end else begin
                rsp_entry_t e;
                e = exp_q.pop_front();
                if ({rsp_res, rsp_cf, rsp_err} !== e) begin
                    bad++;
                    $display("FAIL rsp_data: got res=0x%0h cf=%0b err=%0b expected res=0x%0h cf=%0b err=%0b at %0t",
                             rsp_res, rsp_cf, rsp_err, e.res, e.cf, e.err, $time);
                end
            end
        end
    end

    // Issue one command; returns 1 ns after the accept edge
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit ok;
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got cmd_ready=0 for 200 cycles required 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(ref_rsp(int'(a), int'(b), int'(op)));
        if (op != 2'd3) begin
            last_a  = a;
            last_b  = b;
            last_op = op;
        end
        #1;
        cmd_valid = 1'b0;
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_op    = 2'($urandom);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d responses outstanding required 0", exp_q.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 2'd0; rsp_ready = 1'b0;
        d3_cmd_valid = 1'b0; d3_cmd_a = 8'h00; d3_cmd_b = 8'h00; d3_cmd_op = 2'd0; d3_rsp_ready = 1'b0;
        perturb = 8'h00;
        last_a = 8'h00; last_b = 8'h00; last_op = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_res", {rsp_res, rsp_cf, rsp_err}, 0);
        check("rst_alu", {alu_a, alu_b, alu_opsel}, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        // First command: latency and ready drop
        @(posedge clk); #1;
        send(8'h7F, 8'h01, 2'd0);
        @(negedge clk);
        check("e0_alu_a", alu_a, 8'h7F);
        check("e0_busy", busy, 1);
        check("e0_cmd_ready", cmd_ready, 0);
        check("e0_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("e1_rsp_valid", rsp_valid, 1);
        check("e1_cmd_ready", cmd_ready, 1);
        check("e1_rsp_res", rsp_res, 8'h80);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();

        // Three operations in order
        send(8'hFF, 8'h02, 2'd0);
        send(8'h05, 8'h07, 2'd1);
        send(8'hF0, 8'h3C, 2'd2);
        wait_drain();

        // Fill the FIFO and hold a fifth command
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
        @(posedge clk); #1;
        cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 2'd1; cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_count", count, 4);
            check("full_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("pop1_count", count, 3);
        check("pop1_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        exp_q.push_back(ref_rsp(8'h11, 8'h22, 1));
        last_a = 8'h11; last_b = 8'h22; last_op = 2'd1;
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("fifth_busy", busy, 1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();

        // Reserved opcode keeps the ALU drive unchanged
        send(8'hAA, 8'h55, 2'd3);
        @(negedge clk);
        check("rsvd_alu", {alu_a, alu_b, alu_opsel}, {last_a, last_b, last_op});
        wait_drain();

        // Reset during DRIVE with two results queued
        rsp_ready = 1'b0;
        send(8'h01, 8'h02, 2'd0);
        send(8'h03, 8'h04, 2'd1);
        send(8'h05, 8'h06, 2'd2);
        check("pre_rst_count", count, 2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_count", count, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_alu", {alu_a, alu_b, alu_opsel}, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_rsp", rsp_valid, 0);
        end

        // Randomised traffic with random back-pressure
        @(posedge clk); #1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();

        // SETTLE_CYC=3: capture uses the ALU output present at E0+3
        @(posedge clk); #1;
        d3_cmd_a = 8'h12; d3_cmd_b = 8'h34; d3_cmd_op = 2'd0; d3_cmd_valid = 1'b1;
        @(negedge clk);
        check("s3_cmd_ready", d3_cmd_ready, 1);
        @(posedge clk); #1;
        d3_cmd_valid = 1'b0; d3_cmd_a = 8'hEE; d3_cmd_b = 8'hDD; d3_cmd_op = 2'd2;
        @(negedge clk);
        check("s3_e0_alu", {d3_alu_a, d3_alu_b, d3_alu_opsel}, {8'h12, 8'h34, 2'd0});
        check("s3_e0_busy", d3_busy, 1);
        @(posedge clk); #1 perturb = 8'h5A;
        @(negedge clk);
        check("s3_e1_alu", {d3_alu_a, d3_alu_b, d3_alu_opsel}, {8'h12, 8'h34, 2'd0});
        check("s3_e1_rsp_valid", d3_rsp_valid, 0);
        check("s3_e1_cmd_ready", d3_cmd_ready, 0);
        @(negedge clk);
        check("s3_e2_alu", {d3_alu_a, d3_alu_b, d3_alu_opsel}, {8'h12, 8'h34, 2'd0});
        check("s3_e2_rsp_valid", d3_rsp_valid, 0);
        check("s3_e2_busy", d3_busy, 1);
        @(negedge clk);
        check("s3_e3_rsp_valid", d3_rsp_valid, 1);
        check("s3_e3_rsp", {d3_rsp_res, d3_rsp_cf, d3_rsp_err},
              {ref_rsp(8'h12, 8'h34, 0).res ^ 8'h5A, 1'b0, 1'b0});
        check("s3_e3_cmd_ready", d3_cmd_ready, 1);
        check("s3_e3_alu", {d3_alu_a, d3_alu_b, d3_alu_opsel}, {8'h12, 8'h34, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential initiator for the 8-bit combinational ALU (op_a, op_b, opsel -> res, cf).
- Accepts operation commands over a valid/ready interface and drives the ALU operand/opsel lines from registers.
- Waits a programmable settle time, captures res/cf, and queues the result in a small FIFO for a downstream valid/ready consumer.
- Sits between a command source (CPU stub, bench sequencer) and the ALU instance.

Parameters:
- DATA_W, 8, operand/result width; matches ALU.
- SETTLE_CYC, 1, cycles alu_* are held stable before capture; legal range 1..15.
- DEPTH, 4, result FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_op  in  2  operation select.
- alu_a  out  DATA_W  to ALU op_a.
- alu_b  out  DATA_W  to ALU op_b.
- alu_opsel  out  2  to ALU opsel.
- alu_res  in  DATA_W  from ALU res.
- alu_cf  in  1  from ALU cf.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_res  out  DATA_W  result.
- rsp_cf  out  1  carry flag.
- rsp_err  out  1  reserved opcode was issued.
- busy  out  1  command in flight (state DRIVE).
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; alu_a=0, alu_b=0, alu_opsel=0; FIFO emptied; count=0; rsp_valid=0; rsp_res=0, rsp_cf=0, rsp_err=0; busy=0.
- Reset mid-operation drops the in-flight command and all queued results. No partial result is produced.
- States: IDLE, DRIVE.
- cmd_ready = (state==IDLE) && (count<DEPTH). This is combinational and does not depend on cmd_valid.
- Accept edge E0 (cmd_valid && cmd_ready):
  - Legal cmd_op (0..2): alu_a<=cmd_a, alu_b<=cmd_b, alu_opsel<=cmd_op.
  - Reserved cmd_op=3: alu_* keep their prior values and an err flag is latched.
  - In both cases state->DRIVE and settle counter<=SETTLE_CYC-1.
- DRIVE: counter decrements each edge. On the edge where counter==0, one entry is pushed and state->IDLE.
  - Legal op pushes {alu_res, alu_cf, err=0}.
  - Reserved op pushes {0, 0, err=1}.
- Timing:
  - Result is visible (rsp_valid=1 with an empty FIFO) after edge E0+SETTLE_CYC.
  - Next command can be accepted no earlier than edge E0+SETTLE_CYC+1.
  - Sustained throughput is 1 command per SETTLE_CYC+1 cycles.
- alu_* are stable from E0 until the next accept edge; they never change during DRIVE.
- FIFO is first-word-fall-through: rsp_* show the head whenever count>0. A pop occurs on an edge with rsp_valid && rsp_ready.
- Full: acceptance requires count<DEPTH, so a push never overflows. With count==DEPTH, cmd_ready=0 until a pop.
- Simultaneous push and pop: count is unchanged and the order is preserved (the popped entry is the older one).
- Pop when empty: ignored; rsp_valid=0.
- Read/write pointers wrap modulo DEPTH.
- rsp_* hold their value while rsp_valid && !rsp_ready.
- cmd_* are ignored unless accepted; X on cmd_* while cmd_valid=0 must not propagate to state.

Decomposition:
- Package alu_pkg holds:
  - DATA_W default.
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_RSVD=3.
  - State encoding ST_IDLE/ST_DRIVE.
  - Result-entry struct {res, cf, err}, width DATA_W+2.
- One sub-module: rsp_fifo, a synchronous FWFT FIFO parameterised by width and DEPTH with push/pop/count. The top level contains only the FSM, counter and ALU drive registers.

Test Plan:
- Bench uses a behavioural ALU model with 0=ADD, 1=SUB, 2=AND.
- Reset, then cmd a=0x7F b=0x01 op=0 with SETTLE_CYC=1 -> alu_a=0x7F from E0; rsp_valid after E0+1 with res=0x80, cf=0, err=0; cmd_ready low for 1 cycle after accept.
- a=0xFF b=0x02 op=0, then a=0x05 b=0x07 op=1, then a=0xF0 b=0x3C op=2, rsp_ready=1 -> responses in order: {0x01,cf=1}, {0xFE,cf=1}, {0x30,cf=0}.
- rsp_ready=0, issue 5 commands with DEPTH=4 -> count reaches 4 and cmd_ready stays 0 with the 5th held; raise rsp_ready for 1 cycle -> count=3, 5th accepted, final order intact.
- cmd_op=3 with a=0xAA -> alu_* unchanged from the previous command; response {res=0x00, cf=0, err=1}.
- Assert rst for 1 edge during DRIVE with 2 results queued -> count=0, rsp_valid=0, alu_*=0, cmd_ready=1 next cycle; no stale result ever appears.
- SETTLE_CYC=3, change the ALU model output after 1 cycle -> captured value is the one present at edge E0+3; alu_* stable throughout.
